// File: rtl/vga_pkg.sv
// vga_pkg: 800x600@60 raster constants and types shared by the
// timing generator and the receive-side timing recovery.
package vga_pkg;

  localparam int H_TOTAL      = 1056;
  localparam int H_SYNC       = 128;
  localparam int H_DISP_START = 216;
  localparam int H_DISP_END   = 1015;
  localparam int V_TOTAL      = 628;
  localparam int V_SYNC       = 4;
  localparam int V_DISP_START = 27;
  localparam int V_DISP_END   = 626;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } rec_state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_LINE  = 2'd1,
    ERR_HSYNC = 2'd2,
    ERR_FRAME = 2'd3
  } err_code_t;

  function automatic logic in_win(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: one-stage register on a sync line with
// combinational falling/rising edge pulses.
module sync_edge_det #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= INIT;
    else     d_q <= din;
  end

  assign fall = d_q & ~din;
  assign rise = ~d_q & din;

endmodule

// File: rtl/vga_timing_recover.sv
// vga_timing_recover: rebuilds col/row/blank from incoming HS/VS
// and verifies every line and frame against the raster timing.
module vga_timing_recover
  import vga_pkg::*;
#(
  parameter int WIDTH       = 11,
  parameter int LOCK_FRAMES = 2,
  parameter int H_TOT       = H_TOTAL,
  parameter int H_SW        = H_SYNC,
  parameter int H_DS        = H_DISP_START,
  parameter int H_DE        = H_DISP_END,
  parameter int V_TOT       = V_TOTAL,
  parameter int V_SW        = V_SYNC,
  parameter int V_DS        = V_DISP_START,
  parameter int V_DE        = V_DISP_END
) (
  input  logic       clock_40MHz,
  input  logic       reset,
  input  logic       HS,
  input  logic       VS,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       blank,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_err,
  output logic [1:0] err_code
);

  localparam logic [WIDTH-1:0] H_END   = WIDTH'(H_TOT);
  localparam logic [WIDTH-1:0] H_SWEND = WIDTH'(H_SW);
  localparam logic [WIDTH-1:0] H_MAX   = '1;
  localparam logic [WIDTH-1:0] H_OFS   = WIDTH'(H_DS);
  localparam logic [9:0]       V_LAST  = 10'(V_TOT - 1);
  localparam logic [9:0]       V_SWL   = 10'(V_SW - 1);
  localparam logic [9:0]       V_MAX   = '1;
  localparam logic [9:0]       V_OFS   = 10'(V_DS);
  localparam logic [3:0]       GF_LOCK = 4'(LOCK_FRAMES);

  logic h_fall, h_rise, v_fall, v_rise;

  sync_edge_det u_hs (
    .clk  (clock_40MHz),
    .rst  (reset),
    .din  (HS),
    .fall (h_fall),
    .rise (h_rise)
  );

  sync_edge_det u_vs (
    .clk  (clock_40MHz),
    .rst  (reset),
    .din  (VS),
    .fall (v_fall),
    .rise (v_rise)
  );

  logic [WIDTH-1:0] h_cnt;
  logic [9:0]       v_cnt;
  logic [3:0]       good_frames, gf_nxt;
  rec_state_t       state, state_nxt;
  err_code_t        err_sel;
  logic             chk_on, err, good_vf;
  logic             e_line, e_hsw, e_frm;
  logic             disp;

  // h_fall marks column 0, so loading 1 aligns h_cnt with the source
  always_ff @(posedge clock_40MHz or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_fall)
        h_cnt <= WIDTH'(1);
      else if (h_cnt != H_MAX)
        h_cnt <= h_cnt + WIDTH'(1);
      if (h_fall) begin
        if (v_fall)
          v_cnt <= '0;
        else if (v_cnt != V_MAX)
          v_cnt <= v_cnt + 10'd1;
      end
    end
  end

  assign chk_on = (state != SEARCH);

  always_comb begin
    e_line = 1'b0;
    e_hsw  = 1'b0;
    e_frm  = 1'b0;
    if (chk_on) begin
      e_line = h_fall ? (h_cnt != H_END)
                      : (h_cnt == H_END);
      e_hsw  = h_rise & (h_cnt != H_SWEND);
      e_frm  = (v_fall & (~h_fall | (v_cnt != V_LAST)))
             | (v_rise & ~(h_fall & (v_cnt == V_SWL)))
             | (h_fall & ~v_fall & (v_cnt == V_LAST));
    end
  end

  assign err     = e_line | e_hsw | e_frm;
  assign good_vf = chk_on & v_fall & ~err;

  always_comb begin
    err_sel = ERR_NONE;
    if (e_line)     err_sel = ERR_LINE;
    else if (e_hsw) err_sel = ERR_HSYNC;
    else if (e_frm) err_sel = ERR_FRAME;
  end

  always_comb begin
    state_nxt = state;
    gf_nxt    = good_frames;
    unique case (state)
      SEARCH: begin
        if (h_fall & v_fall) begin
          state_nxt = TRACK;
          gf_nxt    = '0;
        end
      end
      TRACK: begin
        if (err) begin
          state_nxt = SEARCH;
          gf_nxt    = '0;
        end else if (v_fall) begin
          gf_nxt = good_frames + 4'd1;
          if (gf_nxt == GF_LOCK)
            state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (err) begin
          state_nxt = SEARCH;
          gf_nxt    = '0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        gf_nxt    = '0;
      end
    endcase
  end

  assign disp = chk_on
              & in_win(int'(h_cnt), H_DS, H_DE)
              & in_win(int'(v_cnt), V_DS, V_DE);

  always_ff @(posedge clock_40MHz or posedge reset) begin
    if (reset) begin
      state       <= SEARCH;
      good_frames <= '0;
      col         <= '0;
      row         <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      timing_err  <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      state       <= state_nxt;
      good_frames <= gf_nxt;
      blank       <= ~disp;
      col         <= disp ? 10'(h_cnt - H_OFS) : 10'd0;
      row         <= disp ? (v_cnt - V_OFS) : 10'd0;
      frame_start <= good_vf;
      locked      <= (state_nxt == LOCKED);
      timing_err  <= err;
      if (err)
        err_code <= err_sel;
    end
  end

endmodule

// File: tb/tb_vga_timing_recover.sv
// tb_vga_timing_recover: drives a scaled raster generator with fault
// knobs into the recovery block and scoreboards its outputs.
module tb_vga_timing_recover;

  localparam int HT  = 48;
  localparam int HSW = 6;
  localparam int HDS = 10;
  localparam int HDE = 41;
  localparam int VT  = 32;
  localparam int VSW = 2;
  localparam int VDS = 4;
  localparam int VDE = 29;
  localparam int BUDGET = 5 * HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs  = 1'b1;
  logic       vs  = 1'b1;
  logic [9:0] col, row;
  logic       blank, frame_start, locked, timing_err;
  logic [1:0] err_code;

  vga_timing_recover #(
    .WIDTH       (11),
    .LOCK_FRAMES (2),
    .H_TOT       (HT),
    .H_SW        (HSW),
    .H_DS        (HDS),
    .H_DE        (HDE),
    .V_TOT       (VT),
    .V_SW        (VSW),
    .V_DS        (VDS),
    .V_DE        (VDE)
  ) dut (
    .clock_40MHz (clk),
    .reset       (rst),
    .HS          (hs),
    .VS          (vs),
    .col         (col),
    .row         (row),
    .blank       (blank),
    .frame_start (frame_start),
    .locked      (locked),
    .timing_err  (timing_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  gh = 20;
  int  gv = 20;
  int  line_len = HT;
  int  hs_width = HSW;
  int  short_at = -1;
  bit  hs_high = 1'b0;
  bit  sb_en = 1'b0;
  bit  prev_vs = 1'b1;
  bit  fell = 1'b0;
  int  n_vfall = 0;
  int  n_err = 0;
  int  n_fs = 0;
  int  last_h = 0;
  logic [20:0] sb_q[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] gen_px(int h, int v);
    logic d;
    d = (h >= HDS) && (h <= HDE) && (v >= VDS) && (v <= VDE);
    if (d) return {10'(h - HDS), 10'(v - VDS), 1'b0};
    return {10'd0, 10'd0, 1'b1};
  endfunction

  task automatic tick();
    logic [20:0] e;
    hs = hs_high ? 1'b1 : (gh >= hs_width);
    vs = (gv >= VSW);
    fell = prev_vs & ~vs;
    prev_vs = vs;
    if (fell) n_vfall++;
    if (sb_en) sb_q.push_back(gen_px(gh, gv));
    last_h = gh;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("pix", 32'({col, row, blank}), 32'(e));
    end
    if (timing_err) n_err++;
    if (frame_start) n_fs++;
    gh++;
    if (gh >= line_len) begin
      gh = 0;
      line_len = HT;
      hs_width = HSW;
      if (gv == short_at) begin
        gv = 0;
        short_at = -1;
      end else begin
        gv = (gv == VT - 1) ? 0 : gv + 1;
      end
    end
  endtask

  task automatic goto(input int h, input int v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET && !ok; i++) begin
      if (gh == h && gv == v) ok = 1'b1;
      else tick();
    end
    check("goto", 32'(ok), 32'd1);
  endtask

  task automatic wait_err(input string tag,
                          input logic [1:0] code,
                          input int pos);
    int f0;
    bit seen;
    f0 = n_fs;
    seen = 1'b0;
    for (int i = 0; i < BUDGET && !seen; i++) begin
      tick();
      seen = timing_err;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_code"}, 32'(err_code), 32'(code));
    check({tag, "_unlock"}, 32'(locked), 32'd0);
    check({tag, "_pos"}, 32'(last_h), 32'(pos));
    tick();
    check({tag, "_pulse"}, 32'(timing_err), 32'd0);
    check({tag, "_nofs"}, 32'(n_fs - f0), 32'd0);
  endtask

  task automatic wait_lock(input string tag);
    int  v0, e0;
    bit  got;
    v0 = n_vfall;
    e0 = n_err;
    got = 1'b0;
    for (int i = 0; i < BUDGET && !got; i++) begin
      tick();
      got = locked;
    end
    check({tag, "_lock"}, 32'(got), 32'd1);
    check({tag, "_edge"}, 32'(fell), 32'd1);
    check({tag, "_falls"}, 32'(n_vfall - v0), 32'd3);
    check({tag, "_noerr"}, 32'(n_err - e0), 32'd0);
  endtask

  initial begin
    int f0, e0;
    repeat (3) tick();
    check("rst_pix", 32'({col, row, blank}), 32'd1);
    check("rst_flags",
          32'({frame_start, locked, timing_err, err_code}), 32'd0);
    rst = 1'b0;

    wait_lock("acq");
    check("acq_fs", 32'(n_fs), 32'd2);

    f0 = n_fs;
    e0 = n_err;
    sb_en = 1'b1;
    repeat (HT * VT) tick();
    sb_en = 1'b0;
    check("frame_fs", 32'(n_fs - f0), 32'd1);
    check("frame_noerr", 32'(n_err - e0), 32'd0);
    check("frame_locked", 32'(locked), 32'd1);

    goto(0, 10);
    line_len = 40;
    wait_err("cut", 2'd1, 0);
    wait_lock("relock_cut");

    goto(0, 10);
    hs_width = HSW + 5;
    wait_err("hswide", 2'd2, HSW + 5);
    wait_lock("relock_hswide");

    goto(24, 10);
    hs_high = 1'b1;
    wait_err("hshigh", 2'd1, 0);
    hs_high = 1'b0;
    wait_lock("relock_hshigh");

    goto(24, 20);
    gv = 0;
    wait_err("vsmid", 2'd3, 24);
    wait_lock("relock_vsmid");

    goto(0, 20);
    short_at = 20;
    wait_err("short", 2'd3, 0);
    wait_lock("relock_short");

    goto(20, 15);
    check("pre_rst_col", 32'(col), 32'(19 - HDS));
    rst = 1'b1;
    #1;
    check("midrst_pix", 32'({col, row, blank}), 32'd1);
    check("midrst_flags",
          32'({frame_start, locked, timing_err, err_code}), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    wait_lock("relock_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
